// File: rtl/led_flow_pkg.sv
// Shared definitions for the running-LED flow monitor.
//   LED_W_DFLT : width of the LED pattern that the helper functions are sized for
//   state_t    : monitor FSM states
//   is_onehot  : true when exactly one bit of the pattern is set
//   rotate     : expected next pattern (dir 0: led[i] -> led[i+1], dir 1: reverse)
package led_flow_pkg;

    localparam int LED_W_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [LED_W_DFLT-1:0] pat);
        return (pat != '0) && ((pat & (pat - LED_W_DFLT'(1))) == '0);
    endfunction

    function automatic logic [LED_W_DFLT-1:0] rotate(input logic [LED_W_DFLT-1:0] pat,
                                                      input logic                  dir);
        return dir ? {pat[0], pat[LED_W_DFLT-1:1]}
                   : {pat[LED_W_DFLT-2:0], pat[LED_W_DFLT-1]};
    endfunction

endpackage

// File: rtl/led_flow_if.sv
// Bundle between the LED flow monitor and whoever drives/observes it.
//   master : drives en, clr, led_flow; observes the status outputs
//   slave  : the monitor itself
//   en, clr, led_flow       : enable level, counter clear pulse, observed pattern
//   locked, step_ok, err_*  : tracking flag and one-cycle event pulses
//   step_cnt, err_cnt       : saturating event counters
interface led_flow_if
    import led_flow_pkg::*;
#(
    parameter int LED_W  = LED_W_DFLT,
    parameter int STEP_W = 16
);
    logic              en;
    logic              clr;
    logic [LED_W-1:0]  led_flow;
    logic              locked;
    logic              step_ok;
    logic              err_pattern;
    logic              err_order;
    logic              err_timing;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] err_cnt;

    modport master (
        output en, clr, led_flow,
        input  locked, step_ok, err_pattern, err_order, err_timing, step_cnt, err_cnt
    );

    modport slave (
        input  en, clr, led_flow,
        output locked, step_ok, err_pattern, err_order, err_timing, step_cnt, err_cnt
    );
endinterface

// File: rtl/led_flow_dwell_cnt.sv
// Dwell counter for the LED flow monitor.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : pattern change seen this cycle; counter reloads to 1
//   in_window  : dwell count within [DWELL-TOL, DWELL+TOL]
//   stall      : dwell count just passed the upper bound (DWELL+TOL+1)
module led_flow_dwell_cnt #(
    parameter int CNT_W        = 27,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int TOL_CYCLES   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic in_window,
    output logic stall
);

    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(DWELL_CYCLES - TOL_CYCLES);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(DWELL_CYCLES + TOL_CYCLES);
    localparam logic [CNT_W-1:0] STALL_V = CNT_W'(DWELL_CYCLES + TOL_CYCLES + 1);

    logic [CNT_W-1:0] dwell_cnt;

    // Counts cycles since the last change; saturates so a long stall never
    // wraps back into the valid window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (restart) begin
            dwell_cnt <= CNT_W'(1);
        end else if (dwell_cnt != '1) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    assign in_window = (dwell_cnt >= WIN_LO) && (dwell_cnt <= WIN_HI);
    assign stall     = (dwell_cnt == STALL_V);

endmodule

// File: rtl/led_flow_monitor.sv
// Receive-side checker for the rotating one-hot LED pattern.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_flow_if slave (en, clr, led_flow in; locked, step_ok,
//                err_pattern, err_order, err_timing, step_cnt, err_cnt out)
// A change on led_flow is reported two rising edges later; all outputs are
// registered.
module led_flow_monitor
    import led_flow_pkg::*;
#(
    parameter int LED_W        = LED_W_DFLT,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int TOL_CYCLES   = 2,
    parameter int CNT_W        = 27,
    parameter int STEP_W       = 16,
    parameter int DIR          = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    led_flow_if.slave bus
);

    localparam logic DIR_B = (DIR != 0);

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (v == '1) ? v : v + STEP_W'(1);
    endfunction

    state_t            state, state_d;
    logic [LED_W-1:0]  s0, s1;
    logic              change;
    logic              in_window, stall;
    logic              step_d, perr_d, oerr_d, terr_d, err_d;
    logic              locked, step_ok, err_pattern, err_order, err_timing;
    logic [STEP_W-1:0] step_cnt, err_cnt;

    // stage 0: sample the pattern and its previous value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= bus.led_flow;
            s1 <= s0;
        end
    end

    assign change = (s0 != s1);

    led_flow_dwell_cnt #(
        .CNT_W        (CNT_W),
        .DWELL_CYCLES (DWELL_CYCLES),
        .TOL_CYCLES   (TOL_CYCLES)
    ) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (change),
        .in_window (in_window),
        .stall     (stall)
    );

    // stage 1: classify the change and decide the next state
    always_comb begin
        state_d = state;
        step_d  = 1'b0;
        perr_d  = 1'b0;
        oerr_d  = 1'b0;
        terr_d  = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: state_d = ACQUIRE;
                ACQUIRE: begin
                    // First step only needs a valid pair; the dwell before it is unknown.
                    if (change && is_onehot(s1) && is_onehot(s0) && (s0 == rotate(s1, DIR_B))) begin
                        state_d = TRACK;
                        step_d  = 1'b1;
                    end
                end
                TRACK: begin
                    if (change) begin
                        if (!is_onehot(s0))
                            perr_d = 1'b1;
                        else if (s0 != rotate(s1, DIR_B))
                            oerr_d = 1'b1;
                        if (!in_window)
                            terr_d = 1'b1;
                        if (perr_d || oerr_d || terr_d)
                            state_d = ACQUIRE;
                        else
                            step_d = 1'b1;
                    end else if (stall) begin
                        terr_d  = 1'b1;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign err_d = perr_d | oerr_d | terr_d;

    // stage 2: registered status and counters (clr beats a same-cycle increment)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            locked      <= 1'b0;
            step_ok     <= 1'b0;
            err_pattern <= 1'b0;
            err_order   <= 1'b0;
            err_timing  <= 1'b0;
            step_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_d;
            locked      <= (state_d == TRACK);
            step_ok     <= step_d;
            err_pattern <= perr_d;
            err_order   <= oerr_d;
            err_timing  <= terr_d;
            if (bus.clr)
                step_cnt <= '0;
            else if (step_d)
                step_cnt <= sat_inc(step_cnt);
            if (bus.clr)
                err_cnt <= '0;
            else if (err_d)
                err_cnt <= sat_inc(err_cnt);
        end
    end

    assign bus.locked      = locked;
    assign bus.step_ok     = step_ok;
    assign bus.err_pattern = err_pattern;
    assign bus.err_order   = err_order;
    assign bus.err_timing  = err_timing;
    assign bus.step_cnt    = step_cnt;
    assign bus.err_cnt     = err_cnt;

endmodule
